// File: rtl/mips_mc_stall.sv
// Multicycle MIPS subset core (LB/SB/R-type/BEQ/BNE/ADDI/J/HALT) with a memready wait-state handshake.
// Instructions are fetched as four little-endian bytes over memdata[7:0]; data accesses use the full width.
module mips_mc_stall #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] memdata,
    input  logic             memready,
    output logic             memread,
    output logic             memwrite,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] writedata,
    output logic             halted
);

    typedef enum logic [4:0] {
        FETCH1  = 5'd0,  FETCH2  = 5'd1,  FETCH3  = 5'd2,  FETCH4 = 5'd3,
        DECODE  = 5'd4,  MEMADR  = 5'd5,  LBRD    = 5'd6,  LBWR   = 5'd7,
        SBWR    = 5'd8,  RTYPEEX = 5'd9,  RTYPEWR = 5'd10, BEQEX  = 5'd11,
        BNEEX   = 5'd12, ADDIEX  = 5'd13, ADDIWR  = 5'd14, JEX    = 5'd15,
        HALT    = 5'd16
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [WIDTH-1:0]   ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REGBITS-1:0] R0     = {REGBITS{1'b0}};

    state_t             state_r;
    logic [WIDTH-1:0]   pc_r, a_r, b_r, aluout_r, mdr_r;
    logic [31:0]        instr_r;
    logic               rtype_ok_r;
    logic [WIDTH-1:0]   regs_r [0:(2**REGBITS)-1];

    logic [5:0]         op_s, funct_s;
    logic [REGBITS-1:0] rs_s, rt_s, rd_s;
    logic [31:0]        imm32_s;
    logic [WIDTH-1:0]   signimm_s, pc_inc_s, branch_tgt_s, jump_tgt_s;
    logic [WIDTH-1:0]   addr_sum_s, rs_val_s, rt_val_s;
    logic [WIDTH:0]     alu_s;
    logic               unused_s;

    // R-type ALU: MSB of the result flags a recognised funct code
    function automatic logic [WIDTH:0] rtype_alu(input logic [5:0] funct,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] diff;
        diff = a - b;
        case (funct)
            FN_ADD:  rtype_alu = {1'b1, a + b};
            FN_SUB:  rtype_alu = {1'b1, diff};
            FN_AND:  rtype_alu = {1'b1, a & b};
            FN_OR:   rtype_alu = {1'b1, a | b};
            FN_SLT:  rtype_alu = {1'b1, {(WIDTH-1){1'b0}}, diff[WIDTH-1]};
            default: rtype_alu = {1'b0, {WIDTH{1'b0}}};
        endcase
    endfunction

    assign op_s         = instr_r[31:26];
    assign funct_s      = instr_r[5:0];
    assign rs_s         = instr_r[21 +: REGBITS];
    assign rt_s         = instr_r[16 +: REGBITS];
    assign rd_s         = instr_r[11 +: REGBITS];
    assign imm32_s      = {{16{instr_r[15]}}, instr_r[15:0]};
    assign signimm_s    = imm32_s[WIDTH-1:0];
    assign pc_inc_s     = pc_r + ONE_W;
    assign branch_tgt_s = pc_r + {signimm_s[WIDTH-3:0], 2'b00};
    assign jump_tgt_s   = {instr_r[WIDTH-3:0], 2'b00};
    assign addr_sum_s   = a_r + signimm_s;
    assign rs_val_s     = (rs_s == R0) ? ZERO_W : regs_r[rs_s];
    assign rt_val_s     = (rt_s == R0) ? ZERO_W : regs_r[rt_s];
    assign alu_s        = rtype_alu(funct_s, a_r, b_r);
    assign unused_s     = ^{instr_r, imm32_s};

    // Control FSM, datapath registers, register-file writes and registered memory strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= FETCH1;
            pc_r       <= ZERO_W;
            instr_r    <= 32'h0000_0000;
            a_r        <= ZERO_W;
            b_r        <= ZERO_W;
            aluout_r   <= ZERO_W;
            mdr_r      <= ZERO_W;
            rtype_ok_r <= 1'b0;
            memread    <= 1'b1;
            memwrite   <= 1'b0;
            adr        <= ZERO_W;
            writedata  <= ZERO_W;
            halted     <= 1'b0;
        end else begin
            case (state_r)
                FETCH1, FETCH2, FETCH3, FETCH4: begin
                    if (memready) begin
                        instr_r[{state_r[1:0], 3'b000} +: 8] <= memdata[7:0];
                        pc_r <= pc_inc_s;
                        if (state_r == FETCH4) begin
                            state_r <= DECODE;
                            memread <= 1'b0;
                        end else begin
                            state_r <= state_t'(state_r + 5'd1);
                            adr     <= pc_inc_s;
                        end
                    end
                end
                DECODE: begin
                    aluout_r <= branch_tgt_s;
                    a_r      <= rs_val_s;
                    b_r      <= rt_val_s;
                    case (op_s)
                        OP_LB, OP_SB: state_r <= MEMADR;
                        OP_RTYPE:     state_r <= RTYPEEX;
                        OP_BEQ:       state_r <= BEQEX;
                        OP_BNE:       state_r <= BNEEX;
                        OP_ADDI:      state_r <= ADDIEX;
                        OP_J:         state_r <= JEX;
                        OP_HALT: begin
                            state_r <= HALT;
                            halted  <= 1'b1;
                        end
                        default: begin
                            state_r <= FETCH1;
                            memread <= 1'b1;
                            adr     <= pc_r;
                        end
                    endcase
                end
                MEMADR: begin
                    aluout_r <= addr_sum_s;
                    adr      <= addr_sum_s;
                    if (op_s == OP_SB) begin
                        state_r   <= SBWR;
                        memwrite  <= 1'b1;
                        writedata <= b_r;
                    end else begin
                        state_r <= LBRD;
                        memread <= 1'b1;
                    end
                end
                LBRD: begin
                    if (memready) begin
                        mdr_r   <= memdata;
                        memread <= 1'b0;
                        state_r <= LBWR;
                    end
                end
                LBWR: begin
                    if (rt_s != R0) regs_r[rt_s] <= mdr_r;
                    state_r <= FETCH1;
                    memread <= 1'b1;
                    adr     <= pc_r;
                end
                SBWR: begin
                    if (memready) begin
                        memwrite <= 1'b0;
                        memread  <= 1'b1;
                        adr      <= pc_r;
                        state_r  <= FETCH1;
                    end
                end
                RTYPEEX: begin
                    aluout_r   <= alu_s[WIDTH-1:0];
                    rtype_ok_r <= alu_s[WIDTH];
                    state_r    <= RTYPEWR;
                end
                RTYPEWR: begin
                    if (rtype_ok_r && (rd_s != R0)) regs_r[rd_s] <= aluout_r;
                    state_r <= FETCH1;
                    memread <= 1'b1;
                    adr     <= pc_r;
                end
                BEQEX, BNEEX: begin
                    // BNE inverts the equality test; both reuse the target computed in DECODE
                    if ((a_r == b_r) != (state_r == BNEEX)) begin
                        pc_r <= aluout_r;
                        adr  <= aluout_r;
                    end else begin
                        adr  <= pc_r;
                    end
                    state_r <= FETCH1;
                    memread <= 1'b1;
                end
                ADDIEX: begin
                    aluout_r <= addr_sum_s;
                    state_r  <= ADDIWR;
                end
                ADDIWR: begin
                    if (rt_s != R0) regs_r[rt_s] <= aluout_r;
                    state_r <= FETCH1;
                    memread <= 1'b1;
                    adr     <= pc_r;
                end
                JEX: begin
                    pc_r    <= jump_tgt_s;
                    adr     <= jump_tgt_s;
                    state_r <= FETCH1;
                    memread <= 1'b1;
                end
                HALT: begin
                    halted   <= 1'b1;
                    memread  <= 1'b0;
                    memwrite <= 1'b0;
                end
                default: begin
                    state_r  <= FETCH1;
                    memread  <= 1'b1;
                    memwrite <= 1'b0;
                    halted   <= 1'b0;
                    adr      <= pc_r;
                end
            endcase
        end
    end

endmodule
